// File: rtl/tlb_miss_walker.sv
// Shared ITLB/DTLB miss walker: arbitrates the two sticky miss flags (DTLB first),
// fetches one PTE from a single-level page table, then refills the chosen TLB or faults.
module tlb_miss_walker #(
    parameter int ADDR_W  = 32,
    parameter int VPN_W   = 20,
    parameter int TIMEOUT = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_imiss,
    input  logic              i_dmiss,
    input  logic [VPN_W-1:0]  i_ivpn,
    input  logic [VPN_W-1:0]  i_dvpn,
    input  logic [ADDR_W-1:0] i_ptbr,
    output logic              o_iack,
    output logic              o_dack,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_gnt,
    input  logic              i_mem_rvalid,
    input  logic [ADDR_W-1:0] i_mem_rdata,
    output logic              o_refill_we,
    output logic              o_refill_sel,
    output logic [VPN_W-1:0]  o_refill_vpn,
    output logic [ADDR_W-1:0] o_refill_pte,
    output logic              o_fault,
    output logic              o_stall
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t              r_state, w_state_next;
    logic                r_sel, w_sel_next;
    logic [VPN_W-1:0]    r_vpn, w_vpn_next;
    logic [ADDR_W-1:0]   r_pte, w_pte_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic                r_mem_req, w_mem_req_next;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
    logic                r_iack, w_iack_next;
    logic                r_dack, w_dack_next;
    logic                r_we, w_we_next;
    logic                r_fault, w_fault_next;
    logic                r_stall, w_stall_next;
    logic [VPN_W-1:0]    w_miss_vpn;
    logic                w_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 1'b0;
            r_vpn      <= '0;
            r_pte      <= '0;
            r_cnt      <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_iack     <= 1'b0;
            r_dack     <= 1'b0;
            r_we       <= 1'b0;
            r_fault    <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sel      <= w_sel_next;
            r_vpn      <= w_vpn_next;
            r_pte      <= w_pte_next;
            r_cnt      <= w_cnt_next;
            r_mem_req  <= w_mem_req_next;
            r_mem_addr <= w_mem_addr_next;
            r_iack     <= w_iack_next;
            r_dack     <= w_dack_next;
            r_we       <= w_we_next;
            r_fault    <= w_fault_next;
            r_stall    <= w_stall_next;
        end
    end

    // DTLB wins when both flags are up; the ITLB flag stays latched upstream.
    assign w_miss_vpn = i_dmiss ? i_dvpn : i_ivpn;
    assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_state_next    = r_state;
        w_sel_next      = r_sel;
        w_vpn_next      = r_vpn;
        w_pte_next      = r_pte;
        w_cnt_next      = r_cnt;
        w_mem_req_next  = r_mem_req;
        w_mem_addr_next = r_mem_addr;
        w_iack_next     = 1'b0;
        w_dack_next     = 1'b0;
        w_we_next       = 1'b0;
        w_fault_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_dmiss || i_imiss) begin
                    w_sel_next      = i_dmiss;
                    w_vpn_next      = w_miss_vpn;
                    w_mem_req_next  = 1'b1;
                    w_mem_addr_next = i_ptbr + ADDR_W'({w_miss_vpn, 2'b00});
                    w_state_next    = S_REQ;
                end
            end
            S_REQ: begin
                if (i_mem_gnt) begin
                    w_mem_req_next = 1'b0;
                    w_cnt_next     = '0;
                    w_state_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt + CNT_W'(1);
                // Strobes are registered here so they appear during DONE.
                if (i_mem_rvalid) begin
                    w_pte_next   = i_mem_rdata;
                    w_iack_next  = ~r_sel;
                    w_dack_next  = r_sel;
                    w_we_next    = i_mem_rdata[0];
                    w_fault_next = ~i_mem_rdata[0];
                    w_state_next = S_DONE;
                end else if (w_timeout) begin
                    w_iack_next  = ~r_sel;
                    w_dack_next  = r_sel;
                    w_fault_next = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        w_stall_next = (w_state_next != S_IDLE);
    end

    assign o_iack       = r_iack;
    assign o_dack       = r_dack;
    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;
    assign o_refill_we  = r_we;
    assign o_refill_sel = r_sel;
    assign o_refill_vpn = r_vpn;
    assign o_refill_pte = r_pte;
    assign o_fault      = r_fault;
    assign o_stall      = r_stall;
endmodule

// File: tb/tb_tlb_miss_walker.sv
// Scoreboarded bench for tlb_miss_walker: directed test-plan walks, random walks,
// a memory responder that injects grant/response timing, and a decoupled monitor.
module tb_tlb_miss_walker;
    localparam int AW = 32;
    localparam int VW = 20;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst, imiss, dmiss;
    logic [VW-1:0] ivpn, dvpn;
    logic [AW-1:0] ptbr;
    logic          iack, dack, mem_req, refill_we, refill_sel, fault, stall;
    logic [AW-1:0] mem_addr, refill_pte, rdata;
    logic [VW-1:0] refill_vpn;
    logic          gnt, rvalid;

    tlb_miss_walker #(.ADDR_W(AW), .VPN_W(VW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_imiss(imiss), .i_dmiss(dmiss),
        .i_ivpn(ivpn), .i_dvpn(dvpn), .i_ptbr(ptbr),
        .o_iack(iack), .o_dack(dack), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
        .i_mem_gnt(gnt), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
        .o_refill_we(refill_we), .o_refill_sel(refill_sel), .o_refill_vpn(refill_vpn),
        .o_refill_pte(refill_pte), .o_fault(fault), .o_stall(stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit            sel;
        logic [VW-1:0] vpn;
        logic [AW-1:0] addr;
        logic [AW-1:0] pte;
        bit            to;
        bit            fault;
        int            g;
        int            r;
        bit            chained;
        int            start;
        bit            rst_mid;
    } walk_t;

    walk_t exp_q[$];
    walk_t beh_q[$];
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: PTE address is ptbr + 4*vpn modulo 2^AW; invalid PTE or timeout => fault.
    function automatic walk_t mk(input bit sel, input logic [VW-1:0] vpn, input logic [AW-1:0] p,
                                 input int g, input int r, input bit to, input bit val,
                                 input logic [AW-1:0] data);
        walk_t w;
        w.sel     = sel;
        w.vpn     = vpn;
        w.addr    = p + AW'(vpn) * 4;
        w.pte     = val ? (data | 32'h1) : (data & ~32'h1);
        w.to      = to;
        w.fault   = to || !val;
        w.g       = g;
        w.r       = r;
        w.chained = 1'b0;
        w.start   = 0;
        w.rst_mid = 1'b0;
        return w;
    endfunction

    // Upstream miss latches clear on the ack seen at the end of DONE.
    task automatic tick();
        @(negedge clk);
        if (iack) imiss = 1'b0;
        if (dack) dmiss = 1'b0;
    endtask

    task automatic issue(input bit di, input bit ii, input logic [AW-1:0] p,
                         input walk_t wd_in, input walk_t wi_in, input bit exp_en);
        walk_t wd, wi;
        bit    ok = 1'b0;
        wd = wd_in;
        wi = wi_in;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (!imiss && !dmiss && !stall && exp_q.size() == 0 && beh_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("issue_wait", 64'(ok), 64'(1));
        ptbr = p;
        if (di) begin
            dvpn = wd.vpn; dmiss = 1'b1;
            wd.start = cyc;
            if (exp_en) exp_q.push_back(wd);
            beh_q.push_back(wd);
        end
        if (ii) begin
            ivpn = wi.vpn; imiss = 1'b1;
            wi.start = cyc; wi.chained = di;
            if (exp_en) exp_q.push_back(wi);
            beh_q.push_back(wi);
        end
    endtask

    // Memory responder: grant after g cycles, data after r more, or never (timeout).
    initial begin
        walk_t b;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && beh_q.size() > 0) begin
                b = beh_q.pop_front();
                for (int k = 0; k < b.g; k++) begin
                    chk("bp_mem_addr", 64'(mem_addr), 64'(b.addr));
                    chk("bp_mem_req", 64'(mem_req), 64'(1));
                    chk("bp_stall", 64'(stall), 64'(1));
                    @(negedge clk);
                end
                chk("mem_addr", 64'(mem_addr), 64'(b.addr));
                gnt = 1'b1;
                @(negedge clk);
                gnt = 1'b0;
                chk("req_drop", 64'(mem_req), 64'(0));
                if (b.rst_mid) begin
                    @(negedge clk);
                    rvalid = 1'b1; rdata = 32'hCAFE_0001;
                    @(negedge clk);
                    rvalid = 1'b0;
                end else if (b.to) begin
                    repeat (TO) @(negedge clk);
                    rvalid = 1'b1; rdata = $urandom | 32'h1;
                    @(negedge clk);
                    rvalid = 1'b0;
                end else begin
                    repeat (b.r) @(negedge clk);
                    rvalid = 1'b1; rdata = b.pte;
                    @(negedge clk);
                    rvalid = 1'b0;
                end
            end
        end
    end

    // Monitor: every strobe cycle is one completed walk, matched in order.
    initial begin
        walk_t e;
        int    last_done = 0;
        int    done_exp;
        forever begin
            @(negedge clk);
            if (!rst && (iack || dack || refill_we || fault)) begin
                chk("ack_onehot", 64'(iack) + 64'(dack), 64'(1));
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 64'({iack, dack, refill_we, fault}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    done_exp = (e.chained ? last_done + 1 : e.start) +
                               (e.to ? 2 + e.g + TO : 3 + e.g + e.r);
                    chk("done_cycle", 64'(cyc), 64'(done_exp));
                    chk("iack", 64'(iack), 64'(!e.sel));
                    chk("dack", 64'(dack), 64'(e.sel));
                    chk("fault", 64'(fault), 64'(e.fault));
                    chk("refill_we", 64'(refill_we), 64'(!e.fault));
                    chk("stall_done", 64'(stall), 64'(1));
                    if (!e.fault) begin
                        chk("refill_sel", 64'(refill_sel), 64'(e.sel));
                        chk("refill_vpn", 64'(refill_vpn), 64'(e.vpn));
                        chk("refill_pte", 64'(refill_pte), 64'(e.pte));
                    end
                    $display("walk sel=%0d vpn=0x%05h fault=%0d done@%0d", e.sel, e.vpn, e.fault, cyc);
                    last_done = cyc;
                end
            end
        end
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        walk_t w0, w1;
        bit    ok;
        rst = 1'b1; imiss = 1'b0; dmiss = 1'b0; ivpn = '0; dvpn = '0; ptbr = '0;
        repeat (3) tick();
        chk("rst_strobes", 64'({iack, dack, mem_req, refill_we, fault, stall, refill_sel}), 64'(0));
        chk("rst_vpn", 64'(refill_vpn), 64'(0));
        chk("rst_pte", 64'(refill_pte), 64'(0));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        rst = 1'b0;

        // ITLB walk at minimum latency.
        w1 = mk(0, 20'h00012, 32'h8000_0000, 0, 0, 0, 1, 32'h1234_5001);
        issue(0, 1, 32'h8000_0000, w1, w1, 1);
        // Both misses: DTLB first, then ITLB.
        w0 = mk(1, 20'h00003, 32'h4000_0000, 0, 0, 0, 1, 32'h0BAD_F001);
        w1 = mk(0, 20'h00777, 32'h4000_0000, 1, 2, 0, 1, 32'h0000_7001);
        issue(1, 1, 32'h4000_0000, w0, w1, 1);
        // Invalid PTE.
        w1 = mk(0, 20'h00040, 32'h8000_0000, 0, 1, 0, 0, 32'h0000_0000);
        issue(0, 1, 32'h8000_0000, w1, w1, 1);
        // Timeout with a late response.
        w0 = mk(1, 20'h0ABCD, 32'h1000_0000, 0, 0, 1, 1, 32'h0);
        issue(1, 0, 32'h1000_0000, w0, w0, 1);
        // Grant back-pressure, with ptbr near the top to exercise carry drop.
        w0 = mk(1, 20'hFFFFF, 32'hFFF0_0000, 5, 0, 0, 1, 32'h5555_5555);
        issue(1, 0, 32'hFFF0_0000, w0, w0, 1);

        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] p;
            int kind;
            p    = $urandom;
            kind = $urandom_range(0, 2);
            w0 = mk(1, VW'($urandom), p, $urandom_range(0, 4), $urandom_range(0, 3),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom);
            w1 = mk(0, VW'($urandom), p, $urandom_range(0, 4), $urandom_range(0, 3),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom);
            issue(kind != 0, kind != 1, p, w0, w1, 1);
        end

        // Reset in WAIT: the responder returns data after reset, which must be ignored.
        w1 = mk(0, 20'h00099, 32'h2000_0000, 0, 0, 0, 1, 32'h0);
        w1.rst_mid = 1'b1;
        issue(0, 1, 32'h2000_0000, w1, w1, 0);
        tick();
        tick();
        chk("stall_wait", 64'(stall), 64'(1));
        rst = 1'b1; imiss = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_strobes", 64'({iack, dack, mem_req, refill_we, fault, stall, refill_sel}), 64'(0));
        chk("midrst_vpn", 64'(refill_vpn), 64'(0));
        chk("midrst_pte", 64'(refill_pte), 64'(0));
        chk("midrst_addr", 64'(mem_addr), 64'(0));
        tick();
        chk("late_rvalid_we", 64'({refill_we, fault, stall, mem_req}), 64'(0));

        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (exp_q.size() == 0 && beh_q.size() == 0 && !stall) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", 64'(ok), 64'(1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tlb_miss_walker.md
Name: tlb_miss_walker

Overview:
- Consumes the sticky miss flags produced by the ITLB and DTLB miss-latch stages.
- Arbitrates between the two misses and performs a single-level page-table fetch over a simple request/grant/response memory port.
- Writes the fetched PTE back to the selected TLB, or reports a fault.
- Returns a one-cycle ack that clears the selected miss latch, and stalls the pipeline while a walk is in flight.

Parameters:
- ADDR_W, 32, width of memory address, PTBR and PTE.
- VPN_W, 20, virtual page number width.
- TIMEOUT, 64, maximum cycles to wait for mem_rvalid after grant before declaring a fault; must be >= 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- imiss  in  1  sticky ITLB miss flag.
- dmiss  in  1  sticky DTLB miss flag.
- ivpn  in  VPN_W  faulting instruction VPN; held stable while imiss=1.
- dvpn  in  VPN_W  faulting data VPN; held stable while dmiss=1.
- ptbr  in  ADDR_W  page-table base register.
- iack  out  1  one-cycle pulse; clears the ITLB miss latch.
- dack  out  1  one-cycle pulse; clears the DTLB miss latch.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  PTE address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  ADDR_W  PTE data; bit 0 = valid.
- refill_we  out  1  one-cycle PTE write strobe.
- refill_sel  out  1  target TLB: 0 = ITLB, 1 = DTLB.
- refill_vpn  out  VPN_W  VPN being refilled.
- refill_pte  out  ADDR_W  PTE to write.
- fault  out  1  one-cycle pulse: invalid PTE or timeout.
- stall  out  1  high in every non-IDLE state.

Behaviour:
- Reset values:
  - State = IDLE.
  - All outputs 0: iack, dack, mem_req, refill_we, fault, stall, refill_sel, refill_vpn, refill_pte, mem_addr.
  - Timeout counter = 0.
- States and transitions:
  - IDLE: if dmiss, latch sel=1 and vpn=dvpn; else if imiss, latch sel=0 and vpn=ivpn. DTLB has fixed priority. Next state REQ. If neither miss is set, stay in IDLE.
  - REQ: mem_req=1 and mem_addr = ptbr + {vpn, 2'b00}, truncated to ADDR_W, carry dropped. Both are registered and stable until grant. When mem_gnt=1, go to WAIT and clear the counter.
  - WAIT: mem_req=0. Counter increments each cycle.
    - If mem_rvalid=1: capture mem_rdata into refill_pte and go to DONE. mem_rvalid has priority over timeout in the same cycle.
    - If the counter reaches TIMEOUT-1 without rvalid: set the fault cause and go to DONE.
  - DONE (one cycle):
    - Exactly one of iack or dack is asserted, per sel.
    - If the PTE was captured and pte[0]=1: refill_we=1, with refill_sel, refill_vpn and refill_pte valid.
    - Otherwise (pte[0]=0 or timeout): fault=1 and refill_we=0.
    - Next state IDLE.
- Latency and timing:
  - Minimum latency from a miss seen in IDLE to ack is 4 cycles: IDLE, REQ with gnt, WAIT with rvalid, DONE.
  - The ack is seen by the miss latch at the end of DONE. The miss flag is therefore 0 in the following IDLE cycle, so the same miss cannot re-trigger.
- Simultaneous and late events:
  - If both misses are set, DTLB is serviced first. The ITLB miss stays latched upstream and is serviced on the next IDLE cycle.
  - A miss that arrives during a walk is not sampled until IDLE.
  - mem_rvalid outside WAIT is ignored. mem_gnt outside REQ is ignored.
- Reset mid-walk: returns to IDLE immediately with no ack. The upstream latches are reset by the same rst.
- Registered outputs: refill_vpn, refill_sel and refill_pte hold their value after DONE until the next capture. Only the strobes (iack, dack, refill_we, fault) pulse.

Test Plan:
- ITLB miss: imiss=1, ivpn=0x00012, ptbr=0x8000_0000, gnt same cycle, rvalid with 0x1234_5001 one cycle later.
  - Required: mem_addr=0x8000_0048.
  - Required: refill_we=1, refill_sel=0, refill_pte=0x1234_5001 and iack=1 in the same cycle, 4 cycles after the miss; fault=0.
- Simultaneous imiss and dmiss (dvpn=0x00003):
  - Required: DTLB walk first (mem_addr=ptbr+0xC, dack).
  - Required: ITLB walk then starts the cycle after returning to IDLE, ending with iack.
  - Required: never iack and dack together.
- Invalid PTE: rdata=0x0000_0000 → fault=1, refill_we=0, ack still pulses.
- Timeout: gnt given, rvalid never asserted → fault and ack exactly TIMEOUT cycles after entering WAIT. A late rvalid afterwards is ignored.
- Grant back-pressure: gnt held low 5 cycles → mem_req and mem_addr stable for those 5 cycles, stall=1 throughout.
- Reset mid-walk: rst in WAIT → next cycle all outputs 0 and state IDLE. A following rvalid produces no refill_we.
